// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding,
// default bubble instruction and the queue entry layout.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    // Queue entry is {pc, instruction}.
    localparam int ENTRY_W = 64;

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// Two-entry FIFO holding fetched {pc, instruction} pairs; flush empties it
// and cancels any push or pop presented in the same cycle.
module fetch_queue
    import instr_fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [1:0]         count,
    output logic [ENTRY_W-1:0] head
);

    logic [ENTRY_W-1:0] mem_q [2];
    logic [ENTRY_W-1:0] mem_d [2];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0) && !flush;
        do_push  = push && !flush && ((count_q != 2'd2) || do_pop);
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single outstanding word
// reads, buffers responses and handles redirects with a one-cycle nop bubble.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        nop
);

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        tag_pc_q, tag_pc_d;
    logic               nop_q, nop_d;
    logic               outstanding;
    logic               push;
    logic [1:0]         q_count;
    logic [ENTRY_W-1:0] q_head;

    assign outstanding = (state_q == WAIT);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tag_pc_d = tag_pc_q;
        nop_d    = redirect;
        imem_req = 1'b0;
        push     = 1'b0;

        case (state_q)
            REQ: begin
                // Reset also holds the request low so the bus sees idle.
                imem_req = ((q_count + {1'b0, outstanding}) < 2'd2) && !redirect && !rst;
                if (imem_req && imem_gnt) begin
                    tag_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = REQ;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        // Redirect overrides everything; a response landing in the same
        // cycle is consumed and dropped, so no discard phase is needed.
        if (redirect) begin
            push = 1'b0;
            pc_d = redirect_pc & ~32'h3;
            if ((state_q == WAIT && !imem_rvalid) || (state_q == REQ && imem_gnt)) begin
                state_d = DISCARD;
            end else begin
                state_d = REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            tag_pc_q <= RESET_PC;
            nop_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tag_pc_q <= tag_pc_d;
            nop_q    <= nop_d;
        end
    end

    fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({tag_pc_q, imem_rdata}),
        .pop       (inst_valid && inst_ready),
        .flush     (redirect),
        .count     (q_count),
        .head      (q_head)
    );

    assign imem_addr   = pc_q;
    assign inst_valid  = (q_count != 2'd0);
    assign instruction = inst_valid ? q_head[31:0] : NOP_INST;
    assign inst_pc     = inst_valid ? q_head[63:32] : pc_q;
    assign nop         = nop_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised scoreboard bench for instr_fetch_unit with a transaction-level
// memory and instruction-stream reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOPI = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        nop;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .instruction (instruction),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .nop         (nop)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] expq[$];
    logic [31:0] exp_pc;
    logic        exp_nop;
    logic        pending, discarding;
    logic [31:0] pend_pc;
    int          lat_cnt;
    int          lat_lo, lat_hi, gnt_pct, data_mode;
    logic [31:0] gnt_log[$];
    int          cyc, first_gnt, first_valid;
    bit          mon_en;
    int          total, bad;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares the presented head against the expected stream.
    initial begin
        logic [63:0] h;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("inst_valid", 64'(inst_valid), 64'(expq.size() != 0));
                chk("nop", 64'(nop), 64'(exp_nop));
                if (inst_valid && first_valid < 0) first_valid = cyc;
                if (expq.size() != 0) begin
                    h = expq[0];
                    chk("inst_pc", 64'(inst_pc), 64'(h[63:32]));
                    chk("instruction", 64'(instruction), 64'(h[31:0]));
                    if (inst_ready) begin
                        $display("pop pc=%h inst=%h", h[63:32], h[31:0]);
                        void'(expq.pop_front());
                    end
                end else begin
                    chk("empty_inst", 64'(instruction), 64'(NOPI));
                    chk("empty_pc", 64'(inst_pc), 64'(exp_pc));
                end
            end
        end
    end

    // One clock of stimulus plus the model's view of the following edge.
    task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy, input bit stray);
        bit exp_req;
        bit deliver;
        @(negedge clk);
        cyc++;
        imem_gnt    = 1'b0;
        redirect    = rd;
        redirect_pc = rpc;
        inst_ready  = rdy;
        deliver     = pending && (lat_cnt == 1);
        imem_rvalid = stray || deliver;
        if (stray || data_mode == 0) imem_rdata = $urandom;
        else if (data_mode == 1)     imem_rdata = pend_pc;
        else                         imem_rdata = 32'hDEAD_BEEF;
        #1;
        exp_req = !pending && (expq.size() < 2) && !rd;
        chk("imem_req", 64'(imem_req), 64'(exp_req));
        imem_gnt = imem_req && ($urandom_range(0, 99) < gnt_pct);
        #2;
        if (imem_gnt && imem_req) begin
            chk("imem_addr", 64'(imem_addr), 64'(exp_pc));
            gnt_log.push_back(imem_addr);
            if (first_gnt < 0) first_gnt = cyc;
        end
        if (pending && !deliver) lat_cnt--;
        if (rd) begin
            expq.delete();
            if (pending) begin
                if (deliver) pending = 1'b0;
                else         discarding = 1'b1;
            end
            exp_pc = {rpc[31:2], 2'b00};
        end else begin
            if (deliver) begin
                if (!discarding) begin
                    chk("room_for_push", 64'(expq.size() < 2), 64'(1));
                    expq.push_back({pend_pc, imem_rdata});
                end
                pending    = 1'b0;
                discarding = 1'b0;
            end
            if (imem_gnt && imem_req) begin
                pend_pc = exp_pc;
                exp_pc  = exp_pc + 32'd4;
                pending = 1'b1;
                lat_cnt = $urandom_range(lat_lo, lat_hi);
            end
        end
        exp_nop = rd;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 64'(imem_req), 64'(0));
        chk({tag, "_addr"}, 64'(imem_addr), 64'(0));
        chk({tag, "_valid"}, 64'(inst_valid), 64'(0));
        chk({tag, "_inst"}, 64'(instruction), 64'(NOPI));
        chk({tag, "_pc"}, 64'(inst_pc), 64'(0));
        chk({tag, "_nop"}, 64'(nop), 64'(0));
    endtask

    task automatic model_reset();
        expq.delete();
        exp_pc = 32'h0; exp_nop = 1'b0;
        pending = 1'b0; discarding = 1'b0; lat_cnt = 0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        redirect_pc = '0; imem_rdata = '0;
    endtask

    initial begin
        int n;
        total = 0; bad = 0; cyc = 0; mon_en = 1'b0;
        first_gnt = -1; first_valid = -1;
        lat_lo = 1; lat_hi = 1; gnt_pct = 100; data_mode = 1;
        rst = 1'b1;
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Zero-wait memory returning the address as data
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        chk("first_latency", 64'(first_valid - first_gnt), 64'(2));
        n = gnt_log.size();
        chk("gnt_count_ge3", 64'(n >= 3), 64'(1));
        if (n >= 3) begin
            chk("addr0", 64'(gnt_log[0]), 64'(32'h0));
            chk("addr1", 64'(gnt_log[1]), 64'(32'h4));
            chk("addr2", 64'(gnt_log[2]), 64'(32'h8));
        end

        // Backpressure then drain
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        chk("bp_req_low", 64'(imem_req), 64'(0));
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

        // Redirect while a slow response is outstanding
        lat_lo = 3; lat_hi = 3;
        n = 0;
        while (!pending && n < 20) begin step(0, 0, 1, 0); n++; end
        chk("reach_wait", 64'(pending), 64'(1));
        data_mode = 2;
        step(1, 32'h100, 1, 0);
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        data_mode = 1;

        // Misaligned redirect with a full queue
        n = 0;
        while (!(expq.size() == 2 && !pending) && n < 20) begin step(0, 0, 0, 0); n++; end
        chk("queue_full", 64'(expq.size()), 64'(2));
        step(1, 32'h203, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);

        // Redirect coincident with a response
        n = 0;
        while (!(pending && lat_cnt == 1 && expq.size() == 0) && n < 20) begin step(0, 0, 1, 0); n++; end
        chk("reach_coincide", 64'(pending), 64'(1));
        step(1, 32'h300, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);

        // PC wrap
        gnt_log.delete();
        step(1, 32'hFFFF_FFFC, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        chk("wrap_gnts", 64'(gnt_log.size() >= 2), 64'(1));
        if (gnt_log.size() >= 2) begin
            chk("wrap_addr0", 64'(gnt_log[0]), 64'(32'hFFFF_FFFC));
            chk("wrap_addr1", 64'(gnt_log[1]), 64'(32'h0));
        end

        // Reset asserted mid-WAIT with a non-empty queue
        lat_lo = 3; lat_hi = 3;
        n = 0;
        while (!(pending && expq.size() != 0) && n < 40) begin step(0, 0, 0, 0); n++; end
        chk("reach_mid_wait", 64'(pending && expq.size() != 0), 64'(1));
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        lat_lo = 1; lat_hi = 1; gnt_pct = 0;
        step(0, 0, 1, 1);
        gnt_pct = 100; gnt_log.delete();
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        chk("restart_gnt", 64'(gnt_log.size() >= 1), 64'(1));
        if (gnt_log.size() >= 1) chk("restart_addr", 64'(gnt_log[0]), 64'(32'h0));

        // Randomised traffic
        lat_lo = 1; lat_hi = 3; gnt_pct = 70; data_mode = 0;
        for (int i = 0; i < 600; i++) begin
            bit rd;
            rd = !discarding && ($urandom_range(0, 99) < 8);
            step(rd, $urandom, ($urandom_range(0, 99) < 65), 0);
        end

        @(negedge clk);
        #3;
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
